pulse_receiver: RTL and testbench

PULSE_RECEIVER -- requirements
Module: pulse_receiver

---
 rtl/pulse_receiver_if.sv | 13 +
 rtl/pulse_receiver.sv | 143 ++++++++++++++
 tb/tb_pulse_receiver.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pulse_receiver_if.sv
// rtl/pulse_receiver_if.sv - symbol FIFO read port of the pulse receiver
interface pulse_receiver_if #(
  parameter int CNT_W      = 16,
  parameter int FIFO_DEPTH = 4
);
  logic                        rd_en;
  logic [CNT_W:0]              rd_data;
  logic                        rd_valid;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  modport master (output rd_en, input rd_data, rd_valid, fifo_count);
  modport slave  (input rd_en, output rd_data, rd_valid, fifo_count);
endinterface

// File: rtl/pulse_receiver.sv
// rtl/pulse_receiver.sv - measures level durations on a pulse line into a first-word-fall-through symbol FIFO
module pulse_receiver #(
  parameter int CNT_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  input  logic             invert,
  input  logic [7:0]       prescaler,
  input  logic [CNT_W-1:0] idle_timeout,
  input  logic             clr_overflow,
  pulse_receiver_if.slave  rd,
  output logic             overflow,
  output logic             frame_done,
  output logic             busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW:0]   CNT_FULL = FIFO_DEPTH[AW:0];
  localparam logic [AW-1:0] PTR_ONE  = 1;

  typedef enum logic {IDLE, MEASURE} state_t;

  state_t           state;
  logic             sync_q1, sync_q2, line_q;
  logic             line, edge_det, tick, timeout_hit;
  logic             cur_level;
  logic [7:0]       div;
  logic [CNT_W-1:0] dur, dur_next;
  logic [CNT_W:0]   dur_sum;
  logic             push, pop, full, not_empty, wr_ok;
  logic [CNT_W:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;

  assign line     = sync_q2 ^ invert;
  assign edge_det = line != line_q;
  assign tick     = div == prescaler;
  assign dur_sum  = {1'b0, dur} + {{CNT_W{1'b0}}, tick};
  assign dur_next = dur_sum[CNT_W] ? '1 : dur_sum[CNT_W-1:0];
  // Only a high level can end a frame; an edge that cycle wins because push is checked first.
  assign timeout_hit = cur_level && (idle_timeout != '0) && (dur_sum >= {1'b0, idle_timeout});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
      line_q  <= 1'b1;
    end else begin
      sync_q1 <= sig_in;
      sync_q2 <= sync_q1;
      line_q  <= line;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      dur        <= '0;
      div        <= '0;
      cur_level  <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (!en) begin
        state     <= IDLE;
        dur       <= '0;
        div       <= '0;
        cur_level <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            dur <= '0;
            div <= '0;
            if (edge_det && !line) begin
              state     <= MEASURE;
              cur_level <= 1'b0;
              busy      <= 1'b1;
            end
          end
          MEASURE: begin
            if (edge_det) begin
              dur       <= '0;
              div       <= '0;
              cur_level <= ~cur_level;
            end else if (timeout_hit) begin
              state      <= IDLE;
              dur        <= '0;
              div        <= '0;
              cur_level  <= 1'b0;
              frame_done <= 1'b1;
              busy       <= 1'b0;
            end else if (tick) begin
              dur <= dur_next;
              div <= '0;
            end else begin
              div <= div + 8'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign push      = en && (state == MEASURE) && edge_det;
  assign not_empty = count != '0;
  assign full      = count == CNT_FULL;
  assign pop       = rd.rd_en && not_empty;
  // When full, a same-cycle pop frees the slot the push lands in (wr_ptr == rd_ptr).
  assign wr_ok     = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= {cur_level, dur_next};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_ok, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (push && full && !pop) overflow <= 1'b1;
      else if (clr_overflow)    overflow <= 1'b0;
    end
  end

  assign rd.rd_valid   = not_empty;
  assign rd.rd_data    = not_empty ? mem[rd_ptr] : '0;
  assign rd.fifo_count = count;
endmodule

// File: tb/tb_pulse_receiver.sv
// tb/tb_pulse_receiver.sv - directed and randomized checks of pulse_receiver against a duration model
module tb_pulse_receiver;
  localparam int CNT_W = 16;
  localparam int DEPTH = 4;
  localparam int SAT_W = 6;

  logic             clk = 1'b0, rst = 1'b1, en = 1'b0, sig_in = 1'b1, invert = 1'b0, clr_overflow = 1'b0;
  logic [7:0]       prescaler = 8'd0;
  logic [CNT_W-1:0] idle_timeout = '0;
  logic [SAT_W-1:0] idle_timeout_s = '0;
  logic             overflow, frame_done, busy, overflow_s, frame_done_s, busy_s;
  logic             manual_pop = 1'b0;
  bit               reader_on = 1'b0;
  int               cyc = 0, fd_count = 0, n_checks = 0, n_fail = 0;
  int               w, fd0, c_push, p, t, inv, nseg, in_frame, exp_fd, lvl_i;
  int               segs[$];
  logic [CNT_W:0]   got_q[$], exp_q[$];

  pulse_receiver_if #(.CNT_W(CNT_W), .FIFO_DEPTH(DEPTH)) rd_if ();
  pulse_receiver_if #(.CNT_W(SAT_W), .FIFO_DEPTH(2))     sat_if ();

  pulse_receiver #(.CNT_W(CNT_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .en(en), .sig_in(sig_in), .invert(invert), .prescaler(prescaler),
    .idle_timeout(idle_timeout), .clr_overflow(clr_overflow), .rd(rd_if),
    .overflow(overflow), .frame_done(frame_done), .busy(busy));

  pulse_receiver #(.CNT_W(SAT_W), .FIFO_DEPTH(2)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .sig_in(sig_in), .invert(invert), .prescaler(prescaler),
    .idle_timeout(idle_timeout_s), .clr_overflow(clr_overflow), .rd(sat_if),
    .overflow(overflow_s), .frame_done(frame_done_s), .busy(busy_s));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (frame_done) fd_count = fd_count + 1;

  // Single driver of rd_en: free-running reader in random mode, one-shot pops otherwise.
  initial begin
    rd_if.rd_en = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (reader_on && rd_if.rd_valid) got_q.push_back(rd_if.rd_data);
      rd_if.rd_en = manual_pop || (reader_on && rd_if.rd_valid);
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [CNT_W:0] sym(input logic lvl, input int d);
    int sat;
    logic [CNT_W-1:0] dd;
    sat = (d > 65535) ? 65535 : d;
    dd  = sat[CNT_W-1:0];
    return {lvl, dd};
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic lvl, input int n);
    sig_in = lvl;
    cycles(n);
  endtask

  task automatic pop(input string tag, input logic [CNT_W:0] exp);
    check({tag, "_valid"}, rd_if.rd_valid, 1);
    check(tag, rd_if.rd_data, exp);
    manual_pop = 1'b1;
    cycles(1);
    manual_pop = 1'b0;
  endtask

  task automatic wait_fd(input string tag, input int budget);
    int n;
    n = 0;
    while (frame_done !== 1'b1 && n < budget) begin
      cycles(1);
      n++;
    end
    check({tag, "_fd_seen"}, frame_done, 1);
  endtask

  task automatic do_reset();
    en = 1'b0;
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    cycles(2);
  endtask

  initial begin
    sat_if.rd_en = 1'b0;
    cycles(2);
    check("rst_valid", rd_if.rd_valid, 0);
    check("rst_count", rd_if.fifo_count, 0);
    check("rst_data", rd_if.rd_data, 0);
    check("rst_ovf", overflow, 0);
    check("rst_busy", busy, 0);
    check("rst_fd", frame_done, 0);
    rst = 1'b0;
    cycles(2);

    // Basic frame, push latency and timeout timing.
    prescaler = 8'd0; idle_timeout = 16'd50; en = 1'b1;
    cycles(3);
    fd0 = fd_count;
    drive(1'b0, 10);
    sig_in = 1'b1;
    cycles(1); check("lat_k", rd_if.fifo_count, 0);
    cycles(1); check("lat_k1", rd_if.fifo_count, 0);
    cycles(1); check("lat_k2", rd_if.fifo_count, 1);
    check("busy_meas", busy, 1);
    cycles(2);
    drive(1'b0, 7);
    sig_in = 1'b1;
    w = 0;
    while (rd_if.fifo_count != 3 && w < 10) begin cycles(1); w++; end
    check("push3", rd_if.fifo_count, 3);
    c_push = cyc;
    wait_fd("f38", 200);
    check("fd_delay", cyc - c_push, 50);
    check("busy_fall", busy, 0);
    cycles(2);
    check("fd_once", fd_count - fd0, 1);
    pop("s38_0", sym(0, 10));
    pop("s38_1", sym(1, 5));
    pop("s38_2", sym(0, 7));
    check("empty38", rd_if.rd_valid, 0);

    // Prescaler and enable dropped mid-frame.
    prescaler = 8'd3; idle_timeout = 16'd0;
    cycles(2);
    fd0 = fd_count;
    drive(1'b0, 8); drive(1'b1, 10); drive(1'b0, 7); drive(1'b1, 10);
    check("busy_pre_drop", busy, 1);
    en = 1'b0;
    cycles(3);
    check("busy_drop", busy, 0);
    check("cnt_drop", rd_if.fifo_count, 3);
    check("fd_drop", fd_count - fd0, 0);
    pop("s39_0", sym(0, 2));
    pop("s39_1", sym(1, 2));
    pop("s39_2", sym(0, 1));

    // Overflow, set-beats-clear, clear.
    en = 1'b1; prescaler = 8'd0; idle_timeout = 16'd30;
    cycles(2);
    drive(1'b0, 3); drive(1'b1, 4); drive(1'b0, 5); drive(1'b1, 6);
    drive(1'b0, 7); drive(1'b1, 8); drive(1'b0, 9);
    sig_in = 1'b1;
    cycles(3);
    check("ovf_count", rd_if.fifo_count, 4);
    check("ovf_set", overflow, 1);
    wait_fd("fovf", 100);
    clr_overflow = 1'b1;
    drive(1'b0, 3);
    check("ovf_clr_held", overflow, 0);
    sig_in = 1'b1;
    cycles(3);
    check("ovf_set_wins", overflow, 1);
    clr_overflow = 1'b0;
    wait_fd("fovf2", 100);
    clr_overflow = 1'b1; cycles(1); clr_overflow = 1'b0;
    check("ovf_clr", overflow, 0);
    check("ovf_count2", rd_if.fifo_count, 4);
    pop("s40_0", sym(0, 3));
    pop("s40_1", sym(1, 4));
    pop("s40_2", sym(0, 5));
    pop("s40_3", sym(1, 6));

    // Push into a full FIFO with a same-cycle pop.
    drive(1'b0, 2); drive(1'b1, 3); drive(1'b0, 4); drive(1'b1, 5); drive(1'b0, 6);
    check("full_count", rd_if.fifo_count, 4);
    sig_in = 1'b1;
    cycles(2);
    check("full_head", rd_if.rd_data, sym(0, 2));
    manual_pop = 1'b1; cycles(1); manual_pop = 1'b0;
    check("full_pp_count", rd_if.fifo_count, 4);
    check("full_pp_ovf", overflow, 0);
    wait_fd("f41", 100);
    pop("s41_0", sym(1, 3));
    pop("s41_1", sym(0, 4));
    pop("s41_2", sym(1, 5));
    pop("s41_3", sym(0, 6));

    // Edge coinciding with the timeout takes priority.
    idle_timeout = 16'd6;
    fd0 = fd_count;
    drive(1'b0, 4); drive(1'b1, 6); drive(1'b0, 3);
    sig_in = 1'b1;
    wait_fd("fprio", 50);
    cycles(2);
    check("prio_fd", fd_count - fd0, 1);
    pop("sprio_0", sym(0, 4));
    pop("sprio_1", sym(1, 6));
    pop("sprio_2", sym(0, 3));

    // Inverted line, idle low.
    en = 1'b0; invert = 1'b1; sig_in = 1'b0;
    cycles(4);
    idle_timeout = 16'd20; en = 1'b1;
    cycles(2);
    drive(1'b1, 12);
    sig_in = 1'b0;
    wait_fd("finv", 100);
    check("inv_count", rd_if.fifo_count, 1);
    pop("s42_0", sym(0, 12));

    // Asynchronous reset mid-frame, then restart from IDLE.
    en = 1'b0; invert = 1'b0; sig_in = 1'b1;
    cycles(4);
    en = 1'b1; idle_timeout = 16'd30;
    drive(1'b0, 5); drive(1'b1, 3); drive(1'b0, 4);
    check("pre_rst_count", rd_if.fifo_count, 2);
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_valid", rd_if.rd_valid, 0);
    check("arst_count", rd_if.fifo_count, 0);
    check("arst_data", rd_if.rd_data, 0);
    check("arst_fd", frame_done, 0);
    @(negedge clk);
    rst = 1'b0;
    cycles(9);
    sig_in = 1'b1;
    cycles(3);
    check("post_rst_count", rd_if.fifo_count, 1);
    wait_fd("frst", 100);
    pop("srst_0", sym(0, 9));

    // Saturation with timeout disabled, seen on a narrow-counter instance.
    do_reset();
    en = 1'b1; prescaler = 8'd0; idle_timeout = 16'd0;
    cycles(2);
    fd0 = fd_count;
    drive(1'b0, 3); drive(1'b1, 80); drive(1'b0, 2);
    sig_in = 1'b1;
    cycles(3);
    en = 1'b0;
    cycles(2);
    check("sat_fd", fd_count - fd0, 0);
    check("sat_count", sat_if.fifo_count, 2);
    check("sat_ovf", overflow_s, 1);
    check("sat_head", sat_if.rd_data, 7'h03);
    sat_if.rd_en = 1'b1; cycles(1); sat_if.rd_en = 1'b0;
    check("sat_value", sat_if.rd_data, 7'h7F);
    pop("wide_0", sym(0, 3));
    pop("wide_1", sym(1, 80));
    pop("wide_2", sym(0, 2));

    // Randomized frames against the duration model: a level of n cycles measures n/(p+1) ticks.
    do_reset();
    reader_on = 1'b1;
    for (int g = 0; g < 10; g++) begin
      en = 1'b0;
      p = $urandom_range(0, 3);
      t = $urandom_range(1, 20);
      inv = $urandom_range(0, 1);
      prescaler = p[7:0]; idle_timeout = t[CNT_W-1:0]; invert = inv[0]; sig_in = ~inv[0];
      cycles(4);
      en = 1'b1;
      cycles(1);
      segs.delete(); got_q.delete(); exp_q.delete();
      nseg = 2 * $urandom_range(1, 5);
      for (int i = 0; i < nseg; i++) segs.push_back($urandom_range(1, 40));
      segs[nseg-1] = t * (p + 1) + 6;
      exp_fd = 0; in_frame = 0;
      for (int i = 0; i < nseg; i++) begin
        lvl_i = i % 2;
        if (in_frame == 0 && lvl_i == 1) continue;
        in_frame = 1;
        if (lvl_i == 1 && t * (p + 1) < segs[i]) begin
          exp_fd++;
          in_frame = 0;
        end else begin
          exp_q.push_back(sym(lvl_i[0], segs[i] / (p + 1)));
        end
      end
      fd0 = fd_count;
      for (int i = 0; i < nseg; i++) begin
        sig_in = (i % 2 == 1) ^ inv[0];
        cycles(segs[i]);
      end
      cycles(6);
      check($sformatf("rand_g%0d_frames", g), fd_count - fd0, exp_fd);
      check($sformatf("rand_g%0d_busy", g), busy, 0);
      check($sformatf("rand_g%0d_len", g), got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
        check($sformatf("rand_g%0d_s%0d", g, i), got_q[i], exp_q[i]);
    end
    reader_on = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
